// File: rtl/mode_key_ctrl.sv
// mode_key_ctrl
//   Debounces the active-low mode push-button and turns each accepted press
//   into a toggle of the registered mode level feeding the LED chaser.
//   A press held for LONG_CYC cycles after acceptance forces mode back to 0.
//
// Ports
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   key_n      : raw button, active-low, asynchronous and bouncy
//   mode       : registered mode level (0 = sequential, 1 = even/odd)
//   mode_chg   : one-cycle pulse whenever mode changes value
//   long_press : one-cycle pulse when a long press is recognised
module mode_key_ctrl #(
  parameter int DEBOUNCE_CYC = 200000,
  parameter int LONG_CYC     = 20000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic mode,
  output logic mode_chg,
  output logic long_press
);

  localparam int CNT_W = $clog2(LONG_CYC) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             long_fired;
  logic             sync1;
  logic             sync2;
  logic             pressed;

  // Synchroniser: both flops reset to the released level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // Debounce / long-press FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      long_fired <= 1'b0;
      mode       <= 1'b0;
      mode_chg   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      mode_chg   <= 1'b0;
      long_press <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            // bounce: drop back without touching mode
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= PRESSED;
            cnt      <= '0;
            mode     <= ~mode;
            mode_chg <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (!long_fired) begin
            if (cnt == LONG_LAST) begin
              // counter stays parked here for the rest of the press
              long_press <= 1'b1;
              long_fired <= 1'b1;
              if (mode) begin
                mode     <= 1'b0;
                mode_chg <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            // release bounce: resume the hold, keep long_fired
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            long_fired <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
